// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and sizing.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             quotient_bit
);

    localparam int unsigned REM_W = WIDTH + 1;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    // partial_rem never exceeds the divisor, so its top bit is always 0 and
    // widening the shifted value by one bit leaves the comparison unchanged.
    always_comb begin
        shifted     = {partial_rem, dividend_bit};
        divisor_ext = {2'b00, divisor};
        if (shifted >= divisor_ext) begin
            quotient_bit = 1'b1;
            next_rem     = REM_W'(shifted - divisor_ext);
        end else begin
            quotient_bit = 1'b0;
            next_rem     = REM_W'(shifted);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider answering the ALU's div_begin/div_done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_cancel,
    input  logic             div_sign,
    input  logic             div_dividend_sign,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH:0]   partial_rem;
    logic [CNT_W-1:0] iter_cnt;
    logic             sign_q;
    logic             sign_r;
    logic             done_reg;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] r_raw;
    logic             last_step;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial_rem (partial_rem),
        .dividend_bit(dividend_reg[WIDTH-1]),
        .divisor     (divisor_reg),
        .next_rem    (step_rem),
        .quotient_bit(step_q)
    );

    // The quotient fills the vacated LSBs of dividend_reg as it shifts out.
    always_comb begin
        q_raw     = {dividend_reg[WIDTH-2:0], step_q};
        r_raw     = step_rem[WIDTH-1:0];
        last_step = (iter_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= DIV_IDLE;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            partial_rem   <= '0;
            iter_cnt      <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            done_reg      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_cancel) begin
            state    <= DIV_IDLE;
            done_reg <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    done_reg <= 1'b0;
                    if (div_begin) begin
                        dividend_reg <= div_dividend;
                        divisor_reg  <= div_divisor;
                        sign_q       <= div_sign;
                        sign_r       <= div_dividend_sign;
                        partial_rem  <= '0;
                        iter_cnt     <= '0;
                        state        <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    dividend_reg <= q_raw;
                    partial_rem  <= step_rem;
                    iter_cnt     <= iter_cnt + CNT_W'(1);
                    if (last_step) begin
                        div_quotient  <= sign_q ? -q_raw : q_raw;
                        div_remainder <= sign_r ? -r_raw : r_raw;
                        done_reg      <= 1'b1;
                        state         <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    done_reg <= 1'b0;
                    state    <= DIV_IDLE;
                end
                default: begin
                    done_reg <= 1'b0;
                    state    <= DIV_IDLE;
                end
            endcase
        end
    end

    // A flush in the DONE cycle must suppress the pulse in that same cycle.
    assign div_done = done_reg & ~div_cancel;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus reset, back-to-back and cancel sequences.
module tb_seq_divider;

    localparam int unsigned W = 32;
    localparam int NV = 10;

    typedef struct {
        string       name;
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic        sgn;
        logic        dsgn;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          div_begin;
    logic          div_cancel;
    logic          div_sign;
    logic          div_dividend_sign;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic [W-1:0]  div_quotient;
    logic [W-1:0]  div_remainder;
    logic          div_done;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .div_begin        (div_begin),
        .div_cancel       (div_cancel),
        .div_sign         (div_sign),
        .div_dividend_sign(div_dividend_sign),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_quotient     (div_quotient),
        .div_remainder    (div_remainder),
        .div_done         (div_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Returns the number of rising edges until done is seen, or bound+1 if it never is.
    task automatic wait_done(input int bound, output int n);
        n = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (div_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        div_dividend      = v.dividend;
        div_divisor       = v.divisor;
        div_sign          = v.sgn;
        div_dividend_sign = v.dsgn;
    endtask

    // Capture edge plus WIDTH steps: done is first seen after edge W+1.
    task automatic run_vec(input vec_t v);
        int n;
        drive(v);
        div_begin = 1'b1;
        wait_done(W + 8, n);
        check({v.name, " latency"}, n, W + 1);
        check({v.name, " q"}, div_quotient, v.exp_q);
        check({v.name, " r"}, div_remainder, v.exp_r);
        div_begin = 1'b0;
        @(posedge clk);
        #1;
        check({v.name, " done one cycle"}, {31'b0, div_done}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{"u100/7",     32'd100,        32'd7,          1'b0, 1'b0, 32'h0000000E, 32'h00000002};
        vecs[1] = '{"s-7/2",      32'd7,          32'd2,          1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{"min/-1",     32'h80000000,   32'd1,          1'b0, 1'b1, 32'h80000000, 32'h00000000};
        vecs[3] = '{"u5/0",       32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000005};
        vecs[4] = '{"s-5/0",      32'd5,          32'd0,          1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFB};
        vecs[5] = '{"umax/1",     32'hFFFFFFFF,   32'd1,          1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000};
        vecs[6] = '{"umax/umax",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, 32'h00000001, 32'h00000000};
        vecs[7] = '{"u3/10",      32'd3,          32'd10,         1'b0, 1'b0, 32'h00000000, 32'h00000003};
        vecs[8] = '{"s100/-7",    32'd100,        32'd7,          1'b1, 1'b0, 32'hFFFFFFF2, 32'h00000002};
        vecs[9] = '{"u305419896/1000", 32'h12345678, 32'd1000,    1'b0, 1'b0, 32'h0004A90B, 32'h00000380};

        rst = 1'b0;
        div_begin = 1'b0;
        div_cancel = 1'b0;
        div_sign = 1'b0;
        div_dividend_sign = 1'b0;
        div_dividend = '0;
        div_divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done", {31'b0, div_done}, 32'd0);
        check("reset q", div_quotient, 32'd0);
        check("reset r", div_remainder, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Asynchronous reset while step 10 is pending.
        drive(vecs[0]);
        div_begin = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midop reset done", {31'b0, div_done}, 32'd0);
        check("midop reset q", div_quotient, 32'd0);
        check("midop reset r", div_remainder, 32'd0);
        div_begin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_done(W + 8, n);
        check("no done after reset", n, W + 9);
        run_vec(vecs[0]);

        // Back-to-back: begin stays high across done with new operands.
        div_dividend = 32'd100; div_divisor = 32'd7;
        div_sign = 1'b0; div_dividend_sign = 1'b0;
        div_begin = 1'b1;
        wait_done(W + 8, n);
        check("b2b first latency", n, W + 1);
        check("b2b first q", div_quotient, 32'd14);
        div_dividend = 32'd9; div_divisor = 32'd4;
        wait_done(W + 8, n);
        check("b2b second latency", n, W + 2);
        check("b2b second q", div_quotient, 32'd2);
        check("b2b second r", div_remainder, 32'd1);

        // Third op cancelled before step 5; cancel also held against begin in IDLE.
        div_dividend = 32'd50; div_divisor = 32'd3;
        repeat (7) @(posedge clk);
        #1;
        div_cancel = 1'b1;
        check("cancel busy done", {31'b0, div_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        div_cancel = 1'b0;
        div_begin = 1'b0;
        wait_done(W + 8, n);
        check("no done after cancel", n, W + 9);
        check("cancel keeps q", div_quotient, 32'd2);
        check("cancel keeps r", div_remainder, 32'd1);

        // Cancel arriving in the DONE cycle masks the pulse immediately.
        div_dividend = 32'd20; div_divisor = 32'd6;
        div_begin = 1'b1;
        wait_done(W + 8, n);
        check("done cycle latency", n, W + 1);
        check("done cycle q", div_quotient, 32'd3);
        div_cancel = 1'b1;
        #1;
        check("cancel masks done", {31'b0, div_done}, 32'd0);
        div_begin = 1'b0;
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        check("after done cancel", {31'b0, div_done}, 32'd0);
        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
